// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline hazard controller.
//   state_e   : hazard FSM state encoding
//   FWD_*     : ALU operand forward-select codes
//   ctrl_t    : ID/EX control bundle; CTRL_NOP is the bubble value
//   fwd_sel() : one operand's forward select from EX/MEM and MEM/WB
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_FLUSH    = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_ERR      = 2'b11
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] wb_sel;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // EX/MEM is the younger result, so it wins over MEM/WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] mem_rd, input logic mem_we,
                                         input logic [4:0] wb_rd,  input logic wb_we);
    if (mem_we && mem_rd != 5'd0 && mem_rd == rs) return FWD_MEM;
    if (wb_we  && wb_rd  != 5'd0 && wb_rd  == rs) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding unit (purely combinational).
//   id_ex_rs1/rs2       : source registers of the instruction in EX
//   ex_mem_rd/reg_write : destination of the EX/MEM instruction
//   mem_wb_rd/reg_write : destination of the MEM/WB instruction
//   fwd_a/fwd_b         : operand selects (FWD_RF / FWD_WB / FWD_MEM)
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] id_ex_rs1,
  input  logic [4:0] id_ex_rs2,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_reg_write,
  input  logic [4:0] mem_wb_rd,
  input  logic       mem_wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_sel(id_ex_rs1, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
  assign fwd_b = fwd_sel(id_ex_rs2, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
//   Inputs : pipeline register fields (rs/rd/write/load/mem-access),
//            dmem_ready, branch_taken; clk with synchronous active-low reset.
//   Outputs: pc_stall, if_id_stall, id_ex_bubble, if_id_flush, freeze,
//            fwd_a/fwd_b, sticky mem_timeout_err, saturating stall_cycles.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rs1,
  input  logic [4:0]       id_ex_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_reg_write,
  input  logic             ex_mem_mem_access,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_wb_reg_write,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  // Counters only need to hold FLUSH_CYCLES-1 and MEM_TIMEOUT-1.
  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT);
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              lu, mw, in_flush;
  state_e            run_st;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  fwd_unit u_fwd (
    .id_ex_rs1        (id_ex_rs1),
    .id_ex_rs2        (id_ex_rs2),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_reg_write (mem_wb_reg_write),
    .fwd_a            (fwd_a_raw),
    .fwd_b            (fwd_b_raw)
  );

  assign fwd_a           = reset ? fwd_a_raw : FWD_RF;
  assign fwd_b           = reset ? fwd_b_raw : FWD_RF;
  assign mem_timeout_err = err_q;
  assign stall_cycles    = stall_q;

  always_comb begin
    lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
         ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    mw = ex_mem_mem_access && !dmem_ready;
    // Once the memory wait ends, MEM_WAIT behaves exactly like the state it interrupted.
    run_st   = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
    in_flush = (run_st == ST_FLUSH);

    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    freeze       = 1'b0;
    if (reset) begin
      if (state_q == ST_ERR || mw) begin
        freeze      = 1'b1;
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
      end else if (branch_taken || in_flush) begin
        // Squashing the dependent instruction makes any load-use stall moot.
        if_id_flush  = 1'b1;
        id_ex_bubble = branch_taken;
      end else if (lu) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end

    state_d     = state_q;
    ret_d       = ret_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    stall_d     = (pc_stall && stall_q != '1) ? stall_q + 1'b1 : stall_q;

    if (state_q == ST_ERR) begin
      // sticky until reset
    end else if (mw) begin
      if (state_q == ST_MEM_WAIT) begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end else begin
        state_d    = ST_MEM_WAIT;
        ret_d      = state_q;
        wait_cnt_d = WC_W'(1);
      end
    end else begin
      wait_cnt_d = '0;
      state_d    = run_st;
      if (branch_taken) begin
        if (FLUSH_CYCLES > 1) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end else if (in_flush) begin
        if (flush_cnt_q == FC_W'(1)) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  localparam int FC  = 2;
  localparam int MT  = 4;
  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic id_ex_mem_read, ex_mem_reg_write, ex_mem_mem_access, mem_wb_reg_write;
  logic dmem_ready, branch_taken;
  logic pc_stall, if_id_stall, id_ex_bubble, if_id_flush, freeze, mem_timeout_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .ex_mem_mem_access(ex_mem_mem_access),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .freeze(freeze),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: consecutive not-ready cycles, remaining flush cycles,
  // sticky error and the stall tally.
  bit m_err;
  int m_wait, m_flush_left, m_stall;
  bit e_pc, e_ifs, e_bub, e_fl, e_fr;
  logic [1:0] e_fa, e_fb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fsel(input logic [4:0] rs, input logic [4:0] rd1, input logic w1,
                                      input logic [4:0] rd2, input logic w2);
    if (w1 && rd1 != 0 && rd1 == rs) return 2'b10;
    if (w2 && rd2 != 0 && rd2 == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit cur_mw();
    return ex_mem_mem_access && !dmem_ready;
  endfunction

  task automatic clr();
    if_id_rs1 = 0; if_id_rs2 = 0; id_ex_rs1 = 0; id_ex_rs2 = 0; id_ex_rd = 0;
    ex_mem_rd = 0; mem_wb_rd = 0; id_ex_mem_read = 0; ex_mem_reg_write = 0;
    ex_mem_mem_access = 0; mem_wb_reg_write = 0; dmem_ready = 1; branch_taken = 0;
  endtask

  // Let inputs settle, predict outputs, compare every output.
  task automatic eval_check(input string tag);
    bit lu;
    #1;
    lu = id_ex_mem_read && id_ex_rd != 0 && (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
    e_pc = 0; e_ifs = 0; e_bub = 0; e_fl = 0; e_fr = 0; e_fa = 0; e_fb = 0;
    if (reset) begin
      e_fa = fsel(id_ex_rs1, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
      e_fb = fsel(id_ex_rs2, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
      if (m_err || cur_mw()) begin
        e_pc = 1; e_ifs = 1; e_fr = 1;
      end else if (branch_taken || m_flush_left > 0) begin
        e_fl = 1; e_bub = branch_taken;
      end else if (lu) begin
        e_pc = 1; e_ifs = 1; e_bub = 1;
      end
    end
    chk({tag, ".pc_stall"},     32'(pc_stall),        32'(e_pc));
    chk({tag, ".if_id_stall"},  32'(if_id_stall),     32'(e_ifs));
    chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble),    32'(e_bub));
    chk({tag, ".if_id_flush"},  32'(if_id_flush),     32'(e_fl));
    chk({tag, ".freeze"},       32'(freeze),          32'(e_fr));
    chk({tag, ".fwd_a"},        32'(fwd_a),           32'(e_fa));
    chk({tag, ".fwd_b"},        32'(fwd_b),           32'(e_fb));
    chk({tag, ".timeout_err"},  32'(mem_timeout_err), 32'(m_err));
    chk({tag, ".stall_cycles"}, 32'(stall_cycles),    32'(m_stall));
  endtask

  // Advance one clock and the model with it; returns at the falling edge.
  task automatic tick();
    bit mw;
    mw = cur_mw();
    @(posedge clk);
    if (!reset) begin
      m_err = 0; m_wait = 0; m_flush_left = 0; m_stall = 0;
    end else begin
      if (e_pc && m_stall < SAT) m_stall++;
      if (!m_err) begin
        if (mw) begin
          m_wait++;
          if (m_wait == MT) m_err = 1;
        end else begin
          m_wait = 0;
          if (branch_taken) m_flush_left = FC - 1;
          else if (m_flush_left > 0) m_flush_left--;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0; #1; tick(); reset = 1;
  endtask

  initial begin
    clr();
    reset = 0;
    @(posedge clk); @(negedge clk);
    // reset: forwarding-worthy inputs must still give all-zero outputs
    ex_mem_rd = 7; ex_mem_reg_write = 1; id_ex_rs1 = 7; branch_taken = 1;
    eval_check("rst");
    chk("rst.fwd_a_zero", 32'(fwd_a), 0);
    tick();
    reset = 1; clr();

    // load-use: one bubble, then the load has moved on
    id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs2 = 5;
    eval_check("lu");
    chk("lu.bubble1", 32'(id_ex_bubble), 1);
    tick();
    id_ex_mem_read = 0;
    eval_check("lu_after");
    chk("lu.count1", 32'(stall_cycles), 1);
    tick();
    id_ex_mem_read = 1; id_ex_rd = 0; if_id_rs2 = 0;
    eval_check("lu_x0");
    chk("lu_x0.nostall", 32'(pc_stall), 0);
    tick(); clr();

    // forwarding
    ex_mem_rd = 7; mem_wb_rd = 7; ex_mem_reg_write = 1; mem_wb_reg_write = 1;
    id_ex_rs1 = 7; id_ex_rs2 = 0;
    eval_check("fwd_both");
    chk("fwd.a_mem", 32'(fwd_a), 2);
    chk("fwd.b_x0", 32'(fwd_b), 0);
    tick();
    ex_mem_reg_write = 0;
    eval_check("fwd_wb");
    chk("fwd.a_wb", 32'(fwd_a), 1);
    tick(); clr();

    // branch flush for two cycles, bubble on the first
    branch_taken = 1;
    eval_check("br0"); chk("br.flush0", 32'(if_id_flush), 1); chk("br.bub0", 32'(id_ex_bubble), 1);
    tick(); branch_taken = 0;
    eval_check("br1"); chk("br.flush1", 32'(if_id_flush), 1); chk("br.bub1", 32'(id_ex_bubble), 0);
    tick();
    eval_check("br2"); chk("br.flush2", 32'(if_id_flush), 0);
    tick();
    // branch with load-use present: no stall while flushing
    id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs1 = 5; branch_taken = 1;
    eval_check("brlu0"); chk("brlu.nostall0", 32'(pc_stall), 0);
    tick(); branch_taken = 0;
    eval_check("brlu1"); chk("brlu.nostall1", 32'(pc_stall), 0);
    tick();
    eval_check("brlu2");
    tick(); clr();

    // memory wait of three cycles; branch inside it is ignored
    do_reset();
    ex_mem_mem_access = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      branch_taken = (i == 1);
      eval_check("mw"); chk("mw.freeze", 32'(freeze), 1); chk("mw.noflush", 32'(if_id_flush), 0);
      tick();
    end
    branch_taken = 0; dmem_ready = 1;
    eval_check("mw_done");
    chk("mw.unfreeze", 32'(freeze), 0);
    chk("mw.count3", 32'(stall_cycles), 3);
    chk("mw.br_ignored", 32'(if_id_flush), 0);
    tick(); clr();

    // timeout, stickiness and counter saturation
    do_reset();
    ex_mem_mem_access = 1; dmem_ready = 0;
    for (int i = 0; i < MT; i++) begin
      eval_check("to_wait"); chk("to.noerr", 32'(mem_timeout_err), 0);
      tick();
    end
    dmem_ready = 1;
    eval_check("to_err");
    chk("to.err", 32'(mem_timeout_err), 1);
    chk("to.freeze", 32'(freeze), 1);
    tick(); clr();
    for (int i = 0; i < 70; i++) begin
      eval_check("to_hold"); tick();
    end
    eval_check("to_sat");
    chk("to.saturated", 32'(stall_cycles), SAT);
    tick();

    // reset in the middle of a memory wait aborts it
    do_reset(); clr();
    ex_mem_mem_access = 1; dmem_ready = 0;
    for (int i = 0; i < 2; i++) begin eval_check("rmw_pre"); tick(); end
    reset = 0;
    eval_check("rmw_rst"); chk("rmw.rst_freeze", 32'(freeze), 0);
    tick(); reset = 1;
    eval_check("rmw_post0"); chk("rmw.cnt_cleared", 32'(stall_cycles), 0);
    tick();
    for (int i = 0; i < 2; i++) begin eval_check("rmw_post"); tick(); end
    dmem_ready = 1;
    eval_check("rmw_end");
    chk("rmw.noerr", 32'(mem_timeout_err), 0);
    chk("rmw.run", 32'(freeze), 0);
    tick();

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if_id_rs1 = 5'($urandom_range(0, 7));
      if_id_rs2 = 5'($urandom_range(0, 7));
      id_ex_rs1 = 5'($urandom_range(0, 7));
      id_ex_rs2 = 5'($urandom_range(0, 7));
      id_ex_rd  = 5'($urandom_range(0, 7));
      ex_mem_rd = 5'($urandom_range(0, 7));
      mem_wb_rd = 5'($urandom_range(0, 7));
      id_ex_mem_read    = ($urandom_range(0, 2) == 0);
      ex_mem_reg_write  = 1'($urandom_range(0, 1));
      mem_wb_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_mem_access = ($urandom_range(0, 2) == 0);
      dmem_ready        = ($urandom_range(0, 4) > 1);
      branch_taken      = ($urandom_range(0, 5) == 0);
      reset             = ($urandom_range(0, 39) != 0);
      eval_check("rnd");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Generates:
  - PC and IF/ID stall
  - ID/EX bubble insertion (load-use)
  - IF/ID flush on taken branch
  - global freeze while data memory is not ready
  - EX-stage forwarding selects
- Tracks a data-memory timeout and counts stall cycles for performance analysis.
- Drives the `stall` input of the decode stage and the equivalent hold/flush controls of the other stage registers.

Parameters:
- FLUSH_CYCLES, 1: cycles `if_id_flush` stays asserted after a taken branch (≥1).
- MEM_TIMEOUT, 64: consecutive not-ready memory cycles before the error state is entered (≥2).
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- if_id_rs1  in  5  rs1 field of the instruction in IF/ID.
- if_id_rs2  in  5  rs2 field of the instruction in IF/ID.
- id_ex_rs1  in  5  rs1 held in ID/EX.
- id_ex_rs2  in  5  rs2 held in ID/EX.
- id_ex_rd  in  5  rd held in ID/EX.
- id_ex_mem_read  in  1  ID/EX instruction is a load.
- ex_mem_rd  in  5  rd held in EX/MEM.
- ex_mem_reg_write  in  1  EX/MEM writes the register file.
- ex_mem_mem_access  in  1  EX/MEM instruction accesses data memory.
- mem_wb_rd  in  5  rd held in MEM/WB.
- mem_wb_reg_write  in  1  MEM/WB writes the register file.
- dmem_ready  in  1  data memory completes the access this cycle.
- branch_taken  in  1  EX resolved a taken branch or jump.
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  hold IF/ID; this is the `stall` input of the decode stage.
- id_ex_bubble  out  1  load a NOP (all control bits 0) into ID/EX.
- if_id_flush  out  1  replace the IF/ID instruction with a NOP.
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- fwd_a  out  2  ALU operand A select: 00 = register file, 01 = MEM/WB, 10 = EX/MEM.
- fwd_b  out  2  ALU operand B select, same encoding as `fwd_a`.
- mem_timeout_err  out  1  sticky memory-timeout error flag.
- stall_cycles  out  CNT_W  saturating count of cycles with `pc_stall` = 1.

Behaviour:
- Reset (reset = 0 at a rising edge):
  - state = RUN; `flush_cnt` = 0; `wait_cnt` = 0; `stall_cycles` = 0; `mem_timeout_err` = 0.
  - Combinational outputs during reset: all 0, `fwd_a`/`fwd_b` = 00.
  - Reset applied mid-wait or mid-flush aborts that operation immediately.
- FSM states:
  - RUN, FLUSH, MEM_WAIT, ERR.
  - Encodings are defined in the shared package.
- Combinational terms:
  - `lu` = `id_ex_mem_read` & (`id_ex_rd` != 0) & (`id_ex_rd` == `if_id_rs1` | `id_ex_rd` == `if_id_rs2`).
  - `mw` = `ex_mem_mem_access` & !`dmem_ready`.
- Output priority (highest first):
  1. ERR: `freeze` = `pc_stall` = `if_id_stall` = 1; `id_ex_bubble` = `if_id_flush` = 0.
  2. `mw` (in RUN, FLUSH or MEM_WAIT): `freeze` = `pc_stall` = `if_id_stall` = 1; no bubble, no flush; `branch_taken` and `lu` are ignored this cycle.
  3. `branch_taken`, or state = FLUSH: `if_id_flush` = 1.
     - `id_ex_bubble` = 1 only on the `branch_taken` cycle.
     - `lu` is suppressed (the dependent instruction is squashed).
  4. `lu`: `pc_stall` = `if_id_stall` = `id_ex_bubble` = 1. This is exactly one bubble, because the load has advanced on the next cycle.
- Transitions:
  - RUN or FLUSH + `mw` → MEM_WAIT, with `wait_cnt` = 1.
  - MEM_WAIT + `mw` → `wait_cnt` increments.
    - When `wait_cnt` reaches MEM_TIMEOUT − 1 while `mw` is still 1 → ERR, and `mem_timeout_err` = 1.
  - MEM_WAIT + !`mw` → return to the saved return state (RUN or FLUSH, with `flush_cnt` preserved).
    - Outputs that cycle follow priorities 3 and 4.
  - RUN + `branch_taken` (not `mw`):
    - FLUSH_CYCLES > 1 → FLUSH, with `flush_cnt` = FLUSH_CYCLES − 1.
    - Otherwise stay in RUN.
  - FLUSH: `flush_cnt` decrements each non-frozen cycle; → RUN when it reaches 1.
    - A new `branch_taken` in FLUSH reloads `flush_cnt` = FLUSH_CYCLES − 1.
  - ERR: held until reset.
- Forwarding (combinational, independent of FSM state):
  - `fwd_a` = 10 if `ex_mem_reg_write` & `ex_mem_rd` != 0 & `ex_mem_rd` == `id_ex_rs1`.
  - Otherwise `fwd_a` = 01 if `mem_wb_reg_write` & `mem_wb_rd` != 0 & `mem_wb_rd` == `id_ex_rs1`.
  - Otherwise `fwd_a` = 00.
  - `fwd_b` is the same using `id_ex_rs2`.
  - EX/MEM wins when both stages match.
- `stall_cycles`: +1 on each cycle with `pc_stall` = 1; saturates at all-ones (no wrap).

Decomposition:
- Shared package `pipe_pkg` holds:
  - the FSM state encoding
  - the forward-select constants: FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10
  - the NOP control-bundle constant
- Forwarding is split into a sub-module `fwd_unit`, purely combinational and instantiated once, which outputs both `fwd_a` and `fwd_b`.
- The FSM, counters and stall logic stay in `pipe_hazard_ctrl`.

Test Plan:
- Load-use: `id_ex_mem_read` = 1, `id_ex_rd` = 5, `if_id_rs2` = 5 → for exactly one cycle `pc_stall` = `if_id_stall` = `id_ex_bubble` = 1; `stall_cycles` = 1. Repeat with `id_ex_rd` = 0 → no stall.
- Forwarding:
  - `ex_mem_rd` = `mem_wb_rd` = 7, both write, `id_ex_rs1` = 7 → `fwd_a` = 10.
  - Drop `ex_mem_reg_write` → `fwd_a` = 01.
  - `id_ex_rs2` = 0 → `fwd_b` = 00.
- Branch with FLUSH_CYCLES = 2: `branch_taken` pulse → `if_id_flush` = 1 for 2 cycles, `id_ex_bubble` = 1 on the first only. Same stimulus with `lu` true → no stall.
- Memory wait:
  - `ex_mem_mem_access` = 1, `dmem_ready` = 0 for 3 cycles, then 1 → `freeze` = 1 for exactly 3 cycles; `branch_taken` during the wait is ignored.
  - Counter check: `stall_cycles` = 3.
- Timeout with MEM_TIMEOUT = 4: `dmem_ready` held 0 → `mem_timeout_err` = 1 on the 4th cycle and stays 1 with `freeze` = 1 after `dmem_ready` rises.
- Reset mid-operation: reset = 0 for one edge during MEM_WAIT → all outputs and `stall_cycles` return to 0 and the FSM is in RUN next cycle.
